// File: rtl/ula_multiciclo_if.sv
// Handshake and operand/result bus between a requester and the multicycle ALU.
// The master drives the operation request; the slave returns the registered results.
interface ula_multiciclo_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  logic              start;
  logic [OP_W-1:0]   alu_control;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              busy;
  logic              done;
  logic              erro;

  modport master (
    output start, alu_control, a, b,
    input  result, zero, busy, done, erro
  );

  modport slave (
    input  start, alu_control, a, b,
    output result, zero, busy, done, erro
  );
endinterface

// File: rtl/ula_multiciclo.sv
// Multicycle ALU: AND/OR/ADD/SUB complete in one cycle, SRL shifts one bit per cycle.
// Operands are captured on an accepted start and held until the operation completes.
module ula_multiciclo (
  input  logic             clk,
  input  logic             reset,
  ula_multiciclo_if.slave  bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 5;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRL = 4'b0101;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t              state, state_n;
  logic [OP_W-1:0]     op_q, op_n;
  logic [DATA_W-1:0]   a_q, a_n;
  logic [DATA_W-1:0]   b_q, b_n;
  logic [DATA_W-1:0]   sh_q, sh_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [DATA_W-1:0]   result_q, result_n;
  logic                zero_q, zero_n;
  logic                erro_q, erro_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      erro_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      a_q      <= a_n;
      b_q      <= b_n;
      sh_q     <= sh_n;
      cnt_q    <= cnt_n;
      result_q <= result_n;
      zero_q   <= zero_n;
      erro_q   <= erro_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_n  = state;
    op_n     = op_q;
    a_n      = a_q;
    b_n      = b_q;
    sh_n     = sh_q;
    cnt_n    = cnt_q;
    result_n = result_q;
    erro_n   = erro_q;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          op_n    = bus.alu_control;
          a_n     = bus.a;
          b_n     = bus.b;
          state_n = EXEC;
        end
      end
      EXEC: begin
        state_n = DONE;
        erro_n  = 1'b0;
        case (op_q)
          OP_AND: result_n = a_q & b_q;
          OP_OR:  result_n = a_q | b_q;
          OP_ADD: result_n = DATA_W'(a_q + b_q);
          OP_SUB: result_n = DATA_W'(a_q - b_q);
          OP_SRL: begin
            if (b_q[CNT_W-1:0] == '0) begin
              result_n = a_q;
            end else begin
              // Remaining shifts after the first SHIFT cycle
              sh_n    = a_q;
              cnt_n   = CNT_W'(b_q[CNT_W-1:0] - CNT_W'(1));
              erro_n  = erro_q;
              state_n = SHIFT;
            end
          end
          default: begin
            result_n = '0;
            erro_n   = 1'b1;
          end
        endcase
      end
      SHIFT: begin
        sh_n = sh_q >> 1;
        if (cnt_q == '0) begin
          result_n = sh_q >> 1;
          erro_n   = 1'b0;
          state_n  = DONE;
        end else begin
          cnt_n = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    zero_n = (result_n == '0);
    busy_n = (state_n == EXEC) || (state_n == SHIFT);
    done_n = (state_n == DONE);
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.erro   = erro_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: directed cases plus randomized operations
// compared against an arithmetic reference model, sampled on the falling edge.
module tb_ula_multiciclo;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  ula_multiciclo_if bus ();

  ula_multiciclo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: result, error flag and start-to-done latency from the operation rules
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic err, output int lat);
    int sh;
    sh  = int'(b % 32);
    err = 1'b0;
    lat = 1;
    case (op)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: res = a + b;
      4'd4: res = a - b;
      4'd5: begin
        res = a >> sh;
        lat = (sh == 0) ? 1 : sh + 1;
      end
      default: begin
        res = 32'd0;
        err = 1'b1;
      end
    endcase
  endtask

  // Caller is at a falling edge; returns one cycle after done, at a falling edge
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit scr);
    logic [31:0] er;
    logic        ee;
    int          lat;
    int          c;
    int          bc;
    model(op, a, b, er, ee, lat);
    bus.start       = 1'b1;
    bus.alu_control = op;
    bus.a           = a;
    bus.b           = b;
    @(negedge clk);
    c  = 0;
    bc = 0;
    while (bus.done !== 1'b1 && c < 40) begin
      if (bus.busy === 1'b1) bc++;
      if (scr) begin
        bus.a           = $urandom;
        bus.b           = $urandom;
        bus.alu_control = 4'($urandom);
        bus.start       = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    check({tag, "_latency"}, 32'(c), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(lat));
    check({tag, "_result"}, bus.result, er);
    check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, er == 32'd0});
    check({tag, "_erro"}, {31'd0, bus.erro}, {31'd0, ee});
    // A start held through DONE must not be taken
    if (scr) begin
      bus.start       = 1'b1;
      bus.a           = $urandom;
      bus.b           = $urandom;
      bus.alu_control = 4'($urandom);
    end else begin
      bus.start = 1'b0;
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_result_hold"}, bus.result, er);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, bus.result, 32'd0);
    check({tag, "_zero"}, {31'd0, bus.zero}, 32'd1);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_erro"}, {31'd0, bus.erro}, 32'd0);
  endtask

  initial begin
    logic [3:0]  legal [5];
    logic [3:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks = 0;
    n_errors = 0;
    legal[0] = 4'd0; legal[1] = 4'd1; legal[2] = 4'd2; legal[3] = 4'd4; legal[4] = 4'd5;

    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.alu_control = 4'd0;
    bus.a           = 32'd0;
    bus.b           = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_release");

    do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op("sub_neg", 4'b0100, 32'd5, 32'd7, 1'b1);
    do_op("and_b2b", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    do_op("srl31", 4'b0101, 32'h8000_0000, 32'd31, 1'b0);
    do_op("srl0", 4'b0101, 32'h8000_0000, 32'd0, 1'b0);
    do_op("srl5", 4'b0101, 32'h8000_0000, 32'h25, 1'b1);
    do_op("illegal", 4'b0111, 32'd3, 32'd4, 1'b0);
    do_op("or_clr", 4'b0001, 32'd1, 32'd2, 1'b0);
    do_op("srl_scr", 4'b0101, 32'hDEAD_BEEF, 32'd17, 1'b1);

    // Reset in the middle of a long shift aborts it without a done pulse
    bus.start       = 1'b1;
    bus.alu_control = 4'b0101;
    bus.a           = 32'hCAFE_F00D;
    bus.b           = 32'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_shift_rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("no_done_after_abort", {31'd0, bus.done}, 32'd0);
    end
    do_op("after_rst", 4'b0010, 32'd100, 32'd23, 1'b0);

    for (int i = 0; i < 60; i++) begin
      op = legal[$urandom_range(0, 4)];
      if ($urandom_range(0, 5) == 0) op = 4'($urandom);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) ra = rb;
      do_op($sformatf("rnd%0d", i), op, ra, rb, 1'($urandom));
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ula_multiciclo.md
ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-high reset; all state SHALL change only on the rising edge of clk, except when forced by reset.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in state IDLE.
REQ-005 alu_control  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0100 SUB, 0101 SRL; every other code is illegal.
REQ-006 a  input  32  operand A (for SRL, the value to be shifted).
REQ-007 b  input  32  operand B (for SRL, b[4:0] is the shift amount).
REQ-008 result  output  32  registered result; holds its value until the next accepted start completes.
REQ-009 zero  output  1  registered; equals (result == 0).
REQ-010 busy  output  1  high while the FSM is in EXEC or SHIFT.
REQ-011 done  output  1  one-cycle completion pulse, high only in state DONE.
REQ-012 erro  output  1  registered; high when the last completed operation had an illegal code.

Function
REQ-013 The FSM SHALL have the states IDLE, EXEC, SHIFT and DONE; it SHALL be in IDLE after reset.
REQ-014 In IDLE with start=1 at edge k, the block SHALL capture alu_control, a and b into internal registers and enter EXEC; the block SHALL ignore later changes to those inputs until completion.
REQ-015 The block SHALL ignore start in EXEC, SHIFT and DONE; it SHALL neither queue nor acknowledge the request.
REQ-016 EXEC with AND, OR, ADD or SUB SHALL register the result at edge k+1 and enter DONE; ADD and SUB SHALL be modulo 2^32, and carry/overflow SHALL be discarded.
REQ-017 EXEC with SRL and shamt=0 SHALL register result = a at edge k+1 and enter DONE.
REQ-018 EXEC with SRL and shamt=n>0 SHALL load a into the shift register, load n-1 into a 5-bit down-counter and enter SHIFT at edge k+1.
REQ-019 SHIFT SHALL perform a logical right shift by 1 (zero fill) each cycle; at the edge where the counter is 0, it SHALL register the final value into result and enter DONE, so that done is high in the cycle after edge k+n+1.
REQ-020 EXEC with an illegal code SHALL register result = 0 and erro = 1 at edge k+1 and enter DONE; a legal operation SHALL clear erro when its result is registered.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE; the earliest next accepted start SHALL be at edge k+L+2, where L is the operation latency.
REQ-022 zero and erro SHALL update on the same edge as result.
REQ-023 Latency from start edge to done high: 1 cycle for AND/OR/ADD/SUB/illegal codes and SRL with shamt=0; n+1 cycles for SRL with shamt=n (maximum 32 for n=31).
REQ-024 The internal shift counter SHALL NOT wrap; SHIFT SHALL exit exactly when the counter is 0.

Reset
REQ-025 While reset=1, in any state and mid-operation included, the FSM SHALL go to IDLE immediately, and result=0, zero=1, busy=0, done=0, erro=0, with the internal registers cleared.
REQ-026 After reset is released, the block SHALL accept no start until the first rising edge on which reset=0.
REQ-027 A reset asserted during SHIFT SHALL abort the operation; no done pulse SHALL follow for that operation.

Verification
REQ-028 ADD: a=0xFFFFFFFF, b=1, alu_control=0010, start at edge k -> done high after edge k+1, result=0, zero=1, erro=0.
REQ-029 SUB then AND back-to-back: SUB a=5, b=7 -> result=0xFFFFFFFE; next start at the earliest legal edge with AND a=0xF0F0F0F0, b=0xFF00FF00 -> result=0xF000F000; a start pulse held during busy SHALL be ignored.
REQ-030 SRL: a=0x80000000, b=31 -> busy high for 32 cycles, done after edge k+32, result=1; repeat with b=0 -> result=0x80000000 after 1 cycle; b=0x25 (shamt=5) -> result=0x04000000.
REQ-031 Illegal code 0111, a=3, b=4 -> result=0, erro=1, done after 1 cycle; a following OR a=1, b=2 -> result=3, erro=0.
REQ-032 Reset mid-SHIFT: SRL with shamt=20, reset asserted 5 cycles after start -> all outputs at reset values immediately, with no done pulse; a new start after release operates normally.
REQ-033 Operand stability: change a, b and alu_control on every cycle during SHIFT -> result SHALL depend only on the values captured at the start edge.
